// File: rtl/radar_pipe_arbiter.sv
// Round-robin arbiter that locks one radar channel onto the filter pipeline for
// a whole frame, forwarding its points with zero latency and revoking idle grants.
module radar_pipe_arbiter #(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [128*N_CH-1:0]   in_point,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  pipe_ready,
  output logic                  out_valid,
  output logic [127:0]          out_point,
  output logic [2:0]            out_ch,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [2:0]            frame_ch,
  output logic [15:0]           frame_len,
  output logic                  timeout
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  frame_ch_q, frame_ch_d;
  logic [15:0] frame_len_q, frame_len_d;

  // Channels padded to 8 so a 3-bit grant index always lands inside the vector.
  logic [7:0]   valid_pad, last_pad;
  logic [127:0] point_arr [8];
  logic [2:0]   rr_pick;
  logic [15:0]  beat_inc;
  logic         accept;

  always_comb begin
    valid_pad = '0;
    last_pad  = '0;
    for (int i = 0; i < 8; i++) point_arr[i] = '0;
    for (int i = 0; i < N_CH; i++) begin
      valid_pad[i] = in_valid[i];
      last_pad[i]  = in_last[i];
      point_arr[i] = in_point[128*i +: 128];
    end
  end

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    int idx;
    idx     = 0;
    rr_pick = last_grant_q;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % N_CH;
      if (valid_pad[3'(idx)]) rr_pick = 3'(idx);
    end
  end

  assign accept   = (state_q == BURST) && valid_pad[grant_q] && pipe_ready;
  assign beat_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 16'd1;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through this block can leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    frame_ch_d   = frame_ch_q;
    frame_len_d  = frame_len_q;
    in_ready     = '0;
    out_valid    = 1'b0;
    out_point    = '0;
    out_ch       = '0;
    out_last     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d    = rr_pick;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        for (int i = 0; i < N_CH; i++) in_ready[i] = (3'(i) == grant_q) && pipe_ready;
        out_valid = valid_pad[grant_q];
        out_point = point_arr[grant_q];
        out_last  = last_pad[grant_q];
        out_ch    = grant_q;
        if (accept) begin
          beat_cnt_d = beat_inc;
          idle_cnt_d = '0;
          if (last_pad[grant_q]) begin
            frame_done_d = 1'b1;
            frame_ch_d   = grant_q;
            frame_len_d  = beat_inc;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end else if (idle_cnt_q == 8'(TIMEOUT)) begin
          timeout_d    = 1'b1;
          frame_ch_d   = grant_q;
          frame_len_d  = beat_cnt_q;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(N_CH - 1);
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      frame_ch_q   <= '0;
      frame_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      frame_ch_q   <= frame_ch_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign frame_done = frame_done_q;
  assign timeout    = timeout_q;
  assign frame_ch   = frame_ch_q;
  assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_radar_pipe_arbiter.sv
// Directed bench for radar_pipe_arbiter: per-channel point sources feed the DUT
// and every output is compared with hand-computed values through check().
module tb_radar_pipe_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_valid, in_last, in_ready;
  logic [128*N-1:0] in_point;
  logic             pipe_ready;
  logic             out_valid, out_last, frame_done, timeout;
  logic [127:0]     out_point;
  logic [2:0]       out_ch, frame_ch;
  logic [15:0]      frame_len;

  radar_pipe_arbiter #(.N_CH(N), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_point(in_point),
    .in_last(in_last), .in_ready(in_ready), .pipe_ready(pipe_ready),
    .out_valid(out_valid), .out_point(out_point), .out_ch(out_ch),
    .out_last(out_last), .frame_done(frame_done), .frame_ch(frame_ch),
    .frame_len(frame_len), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int           rem [N];
  int           seq [N];
  logic [N-1:0] hold;
  bit           reload;
  int           total = 0;
  int           bad   = 0;
  logic [2:0]   log_ch [$];
  logic [127:0] log_pt [$];

  function automatic logic [127:0] pt(int ch, int s);
    pt = {112'h0, 8'(ch), 8'(s)};
  endfunction

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]              = (rem[i] > 0) && !hold[i];
      in_last[i]               = (rem[i] == 1);
      in_point[128*i +: 128]   = pt(i, seq[i]);
    end
  endtask

  // One clock: record the beat accepted this cycle, advance the sources after
  // the edge, then leave time for combinational outputs to settle.
  task automatic cycle();
    logic [N-1:0] acc;
    acc = in_ready & in_valid;
    if (acc != 0) begin
      log_ch.push_back(out_ch);
      log_pt.push_back(out_point);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] === 1'b1) begin
        seq[i]++;
        rem[i]--;
        if (rem[i] == 0 && reload) rem[i] = 2;
      end
    end
    drive();
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    hold   = '0;
    reload = 1'b0;
    drive();
  endtask

  initial begin
    int exp_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_sq [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
    reset      = 1'b1;
    pipe_ready = 1'b1;
    clear_sources();
    cycle();
    cycle();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_frame_ch", frame_ch, 0);
    check("rst_frame_len", frame_len, 0);

    // Single 3-beat frame on ch1.
    reset  = 1'b0;
    rem[1] = 3;
    drive();
    #1;
    check("s_idle_ready", in_ready, 0);
    check("s_idle_valid", out_valid, 0);
    cycle();
    check("s_valid", out_valid, 1);
    check("s_ch", out_ch, 1);
    check("s_ready", in_ready, 4'b0010);
    check("s_pt0", out_point, pt(1, 0));
    check("s_last0", out_last, 0);
    cycle();
    check("s_pt1", out_point, pt(1, 1));
    cycle();
    check("s_pt2", out_point, pt(1, 2));
    check("s_last2", out_last, 1);
    cycle();
    check("s_done", frame_done, 1);
    check("s_fch", frame_ch, 1);
    check("s_flen", frame_len, 3);
    check("s_ret_valid", out_valid, 0);
    cycle();
    check("s_done_pulse", frame_done, 0);
    check("s_flen_hold", frame_len, 3);

    // All channels requesting continuously, 2-beat frames.
    reset = 1'b1;
    clear_sources();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 2;
    reload = 1'b1;
    log_ch.delete();
    log_pt.delete();
    drive();
    repeat (15) cycle();
    clear_sources();
    check("rr_beats", log_ch.size(), 10);
    for (int i = 0; i < 10 && i < log_ch.size(); i++) begin
      check($sformatf("rr_ch%0d", i), log_ch[i], exp_ch[i]);
      check($sformatf("rr_pt%0d", i), log_pt[i], pt(exp_ch[i], exp_sq[i]));
    end

    // ch2 with pipe_ready low for 5 cycles mid-frame.
    log_ch.delete();
    log_pt.delete();
    rem[2] = 4;
    drive();
    cycle();
    check("bp_ch", out_ch, 2);
    check("bp_ready", in_ready, 4'b0100);
    cycle();
    pipe_ready = 1'b0;
    #1;
    check("bp_ready_low", in_ready, 0);
    check("bp_valid_low", out_valid, 1);
    repeat (4) cycle();
    check("bp_pt_held", out_point, pt(2, 1));
    check("bp_ready_still_low", in_ready, 0);
    pipe_ready = 1'b1;
    #1;
    check("bp_ready_back", in_ready, 4'b0100);
    repeat (3) cycle();
    check("bp_done", frame_done, 1);
    check("bp_fch", frame_ch, 2);
    check("bp_flen", frame_len, 4);
    check("bp_beats", log_pt.size(), 4);
    for (int i = 0; i < 4 && i < log_pt.size(); i++)
      check($sformatf("bp_pt%0d", i), log_pt[i], pt(2, i));

    // ch0 stalls after 2 beats; grant is revoked by the inactivity limit.
    rem[0] = 5;
    drive();
    repeat (3) cycle();
    hold[0] = 1'b1;
    drive();
    #1;
    check("to_valid_off", out_valid, 0);
    check("to_ready", in_ready, 4'b0001);
    for (int k = 1; k <= 64; k++) begin
      cycle();
      if (k == 10) begin
        rem[1] = 2;
        drive();
        #1;
      end
    end
    check("to_not_early", timeout, 0);
    check("to_locked", in_ready, 4'b0001);
    cycle();
    check("to_pulse", timeout, 1);
    check("to_no_done", frame_done, 0);
    check("to_fch", frame_ch, 0);
    check("to_flen", frame_len, 2);
    check("to_idle_ready", in_ready, 0);
    hold[0] = 1'b0;
    drive();
    cycle();
    check("to_next_ch", out_ch, 1);
    check("to_next_valid", out_valid, 1);
    check("to_pulse_end", timeout, 0);
    check("to_flen_hold", frame_len, 2);

    // Reset mid-frame on ch3.
    rem[0] = 0;
    drive();
    cycle();
    cycle();
    check("r_prev_done", frame_done, 1);
    check("r_prev_len", frame_len, 2);
    rem[3] = 10;
    drive();
    cycle();
    check("r_ch3", out_ch, 3);
    cycle();
    reset  = 1'b1;
    rem[1] = 2;
    rem[2] = 2;
    drive();
    cycle();
    check("r_out_valid", out_valid, 0);
    check("r_in_ready", in_ready, 0);
    check("r_out_ch", out_ch, 0);
    check("r_done", frame_done, 0);
    check("r_timeout", timeout, 0);
    check("r_fch", frame_ch, 0);
    check("r_flen", frame_len, 0);
    reset = 1'b0;
    cycle();
    check("r_first_ch", out_ch, 1);
    check("r_first_valid", out_valid, 1);
    check("r_first_ready", in_ready, 4'b0010);

    // Beat accepted in the very cycle the inactivity counter hits the limit.
    reset = 1'b1;
    clear_sources();
    cycle();
    reset  = 1'b0;
    rem[2] = 3;
    drive();
    cycle();
    cycle();
    hold[2] = 1'b1;
    drive();
    repeat (64) cycle();
    check("ed_still_granted", in_ready, 4'b0100);
    check("ed_no_to_yet", timeout, 0);
    hold[2] = 1'b0;
    drive();
    #1;
    check("ed_valid", out_valid, 1);
    cycle();
    check("ed_no_timeout", timeout, 0);
    check("ed_continue", out_valid, 1);
    check("ed_pt", out_point, pt(2, 2));
    check("ed_last", out_last, 1);
    cycle();
    check("ed_done", frame_done, 1);
    check("ed_flen", frame_len, 3);
    check("ed_to_zero", timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
